// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions: opcodes, format tags, field ranges
// and the encoder FIFO entry layout.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned FMT_W   = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [FMT_W-1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

    // Field bit ranges within a 32-bit instruction word
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned JADDR_MSB  = 25;
    localparam int unsigned JADDR_LSB  = 0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
        fmt_e               fmt;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of encoded instruction entries with occupancy count.
// Storage is zeroed on reset only; clear just empties the queue.
module inst_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  fifo_entry_t                  wdata,
    input  logic                         pop,
    output fifo_entry_t                  rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming MIPS field-to-word encoder: packs R/I/J fields, tags each word with
// its byte address and queues it for the instruction-memory write port.
module inst_encoder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [5:0]                   opcode,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  immediate,
    input  logic [25:0]                  address,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_addr,
    output logic [1:0]                   out_type,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  instr_total
);

    logic               full;
    logic               empty;
    logic               accept;
    logic [INSTR_W-1:0] word;
    fmt_e               fmt;
    logic [ADDR_W-1:0]  next_addr;
    fifo_entry_t        wdata;
    fifo_entry_t        head;

    assign in_ready = !full && !clear && !reset;
    assign accept   = in_valid && in_ready;

    // Format selection and field packing; fields unused by the format stay zero
    always_comb begin
        word = '0;
        fmt  = FMT_I;
        word[OPCODE_MSB:OPCODE_LSB] = opcode;
        case (opcode)
            OP_RTYPE: begin
                fmt = FMT_R;
                word[RS_MSB:RS_LSB]       = rs;
                word[RT_MSB:RT_LSB]       = rt;
                word[RD_MSB:RD_LSB]       = rd;
                word[SHAMT_MSB:SHAMT_LSB] = shamt;
                word[FUNCT_MSB:FUNCT_LSB] = funct;
            end
            OP_J, OP_JAL: begin
                fmt = FMT_J;
                word[JADDR_MSB:JADDR_LSB] = address;
            end
            default: begin
                fmt = FMT_I;
                word[RS_MSB:RS_LSB]   = rs;
                word[RT_MSB:RT_LSB]   = rt;
                word[IMM_MSB:IMM_LSB] = immediate;
            end
        endcase
    end

    assign wdata = '{instr: word, addr: next_addr, fmt: fmt};

    // Address tag and accepted-word counter; both wrap naturally
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            next_addr   <= BASE_ADDR;
            instr_total <= '0;
        end else if (accept) begin
            next_addr   <= next_addr + 32'd4;
            instr_total <= instr_total + 16'd1;
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (accept),
        .wdata (wdata),
        .pop   (out_ready),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_valid = !empty;
    assign out_instr = head.instr;
    assign out_addr  = head.addr;
    assign out_type  = head.fmt;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Streaming MIPS instruction encoder: the inverse of the instruction field parser. Accepts decoded fields (opcode, rs, rt, rd, shamt, funct, immediate, address) over a valid/ready handshake and packs them into 32-bit R/I/J instruction words. Tags each word with its byte address and buffers it in a small FIFO. Sits between the test/program loader and the instruction-memory write port.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >= 2)
BASE_ADDR, 32'h0000_0000, byte address assigned to the first word after reset or clear (multiple of 4)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
clear  input  1  synchronous flush: empty FIFO, reload address counter
in_valid  input  1  field tuple present
in_ready  output  1  encoder can accept this cycle
opcode  input  6  instruction opcode
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R-type)
shamt  input  5  shift amount (R-type)
funct  input  6  function code (R-type)
immediate  input  16  immediate (I-type)
address  input  26  jump target field (J-type)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_instr  output  32  encoded instruction word
out_addr  output  32  byte address of out_instr
out_type  output  2  format of out_instr: 0 R, 1 I, 2 J
count  output  $clog2(DEPTH+1)  current FIFO occupancy
instr_total  output  16  number of words accepted since reset/clear, wraps at 2^16

Behaviour:
- Encoding (combinational on inputs, registered on accept):
  - opcode==0: R, word = {opcode, rs, rt, rd, shamt, funct}.
  - opcode==2 or 3: J, word = {opcode, address[25:0]}.
  - else: I, word = {opcode, rs, rt, immediate}.
  - Fields unused by the format are ignored.
- Accept: in_valid && in_ready. in_ready = !full && !clear && !reset. No accept when full, even if a pop occurs the same cycle.
- On accept: push {word, next_addr, type}. next_addr += 4, wrapping 32'hFFFF_FFFC -> 0. instr_total += 1.
- Pop: out_valid && out_ready, advances the read pointer.
  - out_instr, out_addr and out_type are driven from the FIFO head and are stable while out_valid && !out_ready.
  - out_valid = (count != 0).
- Latency: a word accepted in cycle N is visible at the output (out_valid=1) in cycle N+1 when the FIFO was empty. No combinational in->out path.
- Simultaneous push and pop (not full): count unchanged, both pointers advance, ordering preserved.
- Empty: out_valid=0; out_ready is ignored and pointers do not move.
- Full (count==DEPTH): in_ready=0.
- Pointers wrap modulo DEPTH.
- Reset and clear share one effect: pointers=0, count=0, out_valid=0, next_addr=BASE_ADDR, instr_total=0. out_instr/out_addr/out_type read 0 after reset (storage cleared on reset only). Reset has priority over clear.
- Clear asserted with in_valid=1: the tuple is not accepted (in_ready=0). Any pop in the same cycle is discarded.
- Reset or clear mid-stream drops all buffered words. The first word accepted afterwards gets BASE_ADDR.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03
  - out_type encodings FMT_R/FMT_I/FMT_J
  - field bit-range constants, so the parser can adopt them later
- One sub-module: inst_fifo (DEPTH x 66-bit sync FIFO with count). Encoder logic and the address counter live in inst_encoder.

Test Plan:
- Reset, then push add $3,$1,$2 (op 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20) with out_ready=1 -> next cycle out_instr=0x00221820, out_addr=0x0, out_type=0.
- Push addi (op 8, rs 1, rt 2, imm 5) then j (op 2, address 0x0100000) back-to-back -> 0x20220005 @0x0 type 1, then 0x08100000 @0x4 type 2, in order.
- jal with address 0x3FFFFFF, rd/shamt/funct set to garbage -> out_instr=0x0FFFFFFF, type 2 (unused fields ignored).
- out_ready=0, push DEPTH+1 tuples -> in_ready drops after DEPTH accepts, count=DEPTH, instr_total=DEPTH; release out_ready -> all words drain in order with addresses 0,4,8,12.
- BASE_ADDR=32'hFFFF_FFF8, push 3 words -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With 2 words buffered, assert clear together with in_valid -> the next cycle shows out_valid=0, count=0, instr_total=0, and the input was not accepted; the next push gets out_addr=BASE_ADDR.
